// File: rtl/mode_indicator_pkg.sv
// Shared types and helpers for the mode indicator: FSM state encoding,
// mode/LED widths and the mode-to-LED one-hot decode.
package mode_ind_pkg;

  localparam int MODE_W = 2;
  localparam int LED_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEEP = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic logic [LED_W-1:0] mode_onehot(input logic [MODE_W-1:0] mode);
    logic [LED_W-1:0] v;
    v       = '0;
    v[mode] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mode_indicator_if.sv
// Mode-selector to operator-feedback bundle: mode/replay in, LED bank,
// buzzer and busy flag out.
interface mode_indicator_if;
  import mode_ind_pkg::*;

  logic [MODE_W-1:0] sel_type;
  logic              replay;
  logic [LED_W-1:0]  led;
  logic              buzzer;
  logic              busy;

  modport master (output sel_type, replay, input led, buzzer, busy);
  modport slave  (input sel_type, replay, output led, buzzer, busy);

endinterface

// File: rtl/mode_indicator_timer.sv
// Module ind_interval_timer: cycle counter cleared by load that saturates at
// term; done is high while the count sits at term.
module ind_interval_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] term,
  output logic         done
);

  logic [W-1:0] count;

  // Saturating at term means a late load can never wrap the interval.
  always_ff @(posedge clk) begin
    if (rst || load)
      count <= '0;
    else if (count != term)
      count <= count + W'(1);
  end

  assign done = (count == term);

endmodule

// File: rtl/mode_indicator.sv
// Reports the drive mode on a one-hot LED bank and sounds mode+1 beeps on every
// mode change or replay request. Define MODE_IND_LED_BLINK_EN to blink the LED with the buzzer.
module mode_indicator
  import mode_ind_pkg::*;
#(
  parameter int BEEP_CYC    = 5_000_000,
  parameter int GAP_CYC     = 5_000_000,
  parameter bit BUZZ_ACTIVE = 1'b1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  mode_indicator_if.slave  bus
);

  localparam int MAX_CYC = (BEEP_CYC > GAP_CYC) ? BEEP_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] BEEP_TERM = CNT_W'(BEEP_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(GAP_CYC - 1);

  state_t            state;
  logic [MODE_W-1:0] mode_q;
  logic [LED_W-1:0]  led_q;
  logic [2:0]        beeps_left;
  logic              buzz_on;
  logic              busy_q;

  logic              change;
  logic              start;
  logic              timer_done;
  logic              timer_load;
  logic [CNT_W-1:0]  term;

  // A mode change restarts from any state; replay only counts while idle.
  assign change     = (bus.sel_type != mode_q);
  assign start      = change || ((state == IDLE) && bus.replay);
  assign term       = (state == GAP) ? GAP_TERM : BEEP_TERM;
  assign timer_load = start || (state == IDLE) || timer_done;

  ind_interval_timer #(.W(CNT_W)) u_timer (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .load (timer_load),
    .term (term),
    .done (timer_done)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      mode_q     <= '0;
      led_q      <= mode_onehot(MODE_W'(0));
      beeps_left <= '0;
      buzz_on    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      mode_q <= bus.sel_type;
      led_q  <= mode_onehot(bus.sel_type);
      if (start) begin
        state      <= BEEP;
        beeps_left <= {1'b0, bus.sel_type} + 3'd1;
        buzz_on    <= 1'b1;
        busy_q     <= 1'b1;
      end else begin
        case (state)
          BEEP: begin
            if (timer_done) begin
              buzz_on <= 1'b0;
              if (beeps_left == 3'd1) begin
                state      <= IDLE;
                beeps_left <= '0;
                busy_q     <= 1'b0;
              end else begin
                state      <= GAP;
                beeps_left <= beeps_left - 3'd1;
              end
            end
          end
          GAP: begin
            if (timer_done) begin
              state   <= BEEP;
              buzz_on <= 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            buzz_on <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.buzzer = buzz_on ^ ~BUZZ_ACTIVE;
  assign bus.busy   = busy_q;

`ifdef MODE_IND_LED_BLINK_EN
  assign bus.led = busy_q ? (led_q & {LED_W{buzz_on}}) : led_q;
`else
  assign bus.led = led_q;
`endif

endmodule
